regfile_sb: RTL and testbench

Parametrised general-purpose register file for the miniRISC datapath: two combinational read ports, one write port with optional write-through bypass, and an optional hardwired-zero register 0. Adds a per-register scoreboard (busy bits) so the hazard unit can stall on pending multi-cycle writebacks, plus a sequential dump engine that streams every register out over a valid/ready port for the board debug/display path. Sits in the decode stage, replacing the fixed 32x32 file.

---
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_sb.sv | 106 ++++++++++
 tb/tb_regfile_sb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, write/issue ports, display tap and dump stream.
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DISP_W = 16
);
   logic [ADDR_W-1:0] rs, rt;
   logic [DATA_W-1:0] rd1, rd2;
   logic              rs_busy, rt_busy;
   logic              write_reg;
   logic [ADDR_W-1:0] wr;
   logic [DATA_W-1:0] write;
   logic              issue;
   logic [ADDR_W-1:0] iss_reg;
   logic [ADDR_W-1:0] disp;
   logic [DISP_W-1:0] out;
   logic              dump_start;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic              dump_done;

   modport master (
      output rs, rt, write_reg, wr, write, issue, iss_reg, disp, dump_start, dump_ready,
      input  rd1, rd2, rs_busy, rt_busy, out, dump_valid, dump_idx, dump_data, dump_done
   );

   modport slave (
      input  rs, rt, write_reg, wr, write, issue, iss_reg, disp, dump_start, dump_ready,
      output rd1, rd2, rs_busy, rt_busy, out, dump_valid, dump_idx, dump_data, dump_done
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, write-through bypass,
// optional hardwired zero register and a valid/ready register dump engine.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int DISP_W   = 16
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {S_IDLE, S_DUMP} state_t;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic [DEPTH-1:0]             busy;
   logic                         wr_en, iss_en;
   logic                         hit_s, hit_t;
   state_t                       state, state_nxt;
   logic [ADDR_W-1:0]            idx;
   logic                         done;
   logic                         accept, last;

   // writes and issues aimed at the hardwired zero register are dropped here
   assign wr_en  = bus.write_reg && !((ZERO_REG != 0) && (bus.wr == '0));
   assign iss_en = bus.issue && !((ZERO_REG != 0) && (bus.iss_reg == '0));

   // register storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        regs <= '0;
      else if (wr_en) regs[bus.wr] <= bus.write;
   end

   // scoreboard: write clears, issue sets; issue is applied last so a new producer wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (wr_en)  busy[bus.wr]      <= 1'b0;
         if (iss_en) busy[bus.iss_reg] <= 1'b1;
      end
   end

   assign hit_s = (BYPASS != 0) && wr_en && (bus.wr == bus.rs);
   assign hit_t = (BYPASS != 0) && wr_en && (bus.wr == bus.rt);

   // read ports with write-through bypass; a same-cycle issue keeps the bypassed reg busy
   always_comb begin
      bus.rd1     = hit_s ? bus.write : regs[bus.rs];
      bus.rd2     = hit_t ? bus.write : regs[bus.rt];
      bus.rs_busy = hit_s ? (iss_en && (bus.iss_reg == bus.rs)) : busy[bus.rs];
      bus.rt_busy = hit_t ? (iss_en && (bus.iss_reg == bus.rt)) : busy[bus.rt];
      if ((ZERO_REG != 0) && (bus.rs == '0)) begin
         bus.rd1     = '0;
         bus.rs_busy = 1'b0;
      end
      if ((ZERO_REG != 0) && (bus.rt == '0)) begin
         bus.rd2     = '0;
         bus.rt_busy = 1'b0;
      end
   end

   // display tap reads stored state only
   assign bus.out = regs[bus.disp][DISP_W-1:0];

   assign accept = (state == S_DUMP) && bus.dump_ready;
   assign last   = (idx == {ADDR_W{1'b1}});

   // dump FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // dump FSM next state; dump_start only matters in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.dump_start) state_nxt = S_DUMP;
         S_DUMP: if (accept && last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // dump FSM outputs; data is the stored value so a pending write shows once it lands
   always_comb begin
      bus.dump_valid = (state == S_DUMP);
      bus.dump_idx   = idx;
      bus.dump_data  = regs[idx];
      bus.dump_done  = done;
   end

   // dump index advances only on acceptance and wraps to 0 after the last word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx  <= '0;
         done <= 1'b0;
      end else begin
         done <= accept && last;
         if (accept) idx <= last ? '0 : idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table for read/write/scoreboard
// behaviour, queued expectations for the dump stream, and reset-during-dump.
module tb_regfile_sb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .DISP_W(16)) bus();

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .DISP_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        iss;
      logic [4:0]  iss_reg;
      logic [4:0]  rs, rt, disp;
      logic [31:0] e_rd1, e_rd2;
      logic        e_sb, e_tb;
      logic [15:0] e_out;
   } vec_t;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } dump_t;

   vec_t  vec [13];
   dump_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.write_reg = 0; bus.wr = 0; bus.write = 0; bus.issue = 0; bus.iss_reg = 0;
      bus.rs = 0; bus.rt = 0; bus.disp = 0; bus.dump_start = 0; bus.dump_ready = 0;
   endtask

   task automatic fill();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         bus.write_reg = 1; bus.wr = 5'(i); bus.write = 32'(i * 3);
      end
      @(negedge clk);
      bus.write_reg = 0;
   endtask

   initial begin
      dump_t  e, held;
      logic   stall;
      int     accepted, done_cnt, tail, cyc;
      logic   wrote;

      //          we wr  wd            iss ir  rs  rt  dsp  rd1           rd2           sb tb out
      vec[0]  = '{0, 0,  32'h0,        0,  0,  3,  31, 0,   32'h0,        32'h0,        0, 0, 16'h0};
      vec[1]  = '{1, 5,  32'hDEADBEEF, 0,  0,  5,  5,  5,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 16'h0};
      vec[2]  = '{0, 0,  32'h0,        0,  0,  5,  0,  5,   32'hDEADBEEF, 32'h0,        0, 0, 16'hBEEF};
      vec[3]  = '{1, 0,  32'h1234,     1,  0,  0,  0,  0,   32'h0,        32'h0,        0, 0, 16'h0};
      vec[4]  = '{0, 0,  32'h0,        0,  0,  0,  5,  0,   32'h0,        32'hDEADBEEF, 0, 0, 16'h0};
      vec[5]  = '{0, 0,  32'h0,        1,  7,  7,  7,  7,   32'h0,        32'h0,        0, 0, 16'h0};
      vec[6]  = '{0, 0,  32'h0,        0,  0,  0,  7,  7,   32'h0,        32'h0,        0, 1, 16'h0};
      vec[7]  = '{1, 7,  32'hAA,       1,  7,  7,  7,  7,   32'hAA,       32'hAA,       1, 1, 16'h0};
      vec[8]  = '{0, 0,  32'h0,        0,  0,  0,  7,  7,   32'h0,        32'hAA,       0, 1, 16'hAA};
      vec[9]  = '{1, 7,  32'hBB,       0,  0,  0,  7,  7,   32'h0,        32'hBB,       0, 0, 16'hAA};
      vec[10] = '{0, 0,  32'h0,        0,  0,  0,  7,  7,   32'h0,        32'hBB,       0, 0, 16'hBB};
      vec[11] = '{1, 3,  32'h33,       1,  9,  3,  9,  3,   32'h33,       32'h0,        0, 0, 16'h0};
      vec[12] = '{0, 0,  32'h0,        0,  0,  9,  3,  3,   32'h0,        32'h33,       1, 0, 16'h33};

      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_dump_valid", 32'(bus.dump_valid), 0);
      chk("reset_dump_idx", 32'(bus.dump_idx), 0);
      chk("reset_dump_done", 32'(bus.dump_done), 0);
      rst = 0;

      // vector table: drive at negedge, check combinational outputs, let the edge commit
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         bus.write_reg = vec[i].we; bus.wr = vec[i].wr; bus.write = vec[i].wd;
         bus.issue = vec[i].iss; bus.iss_reg = vec[i].iss_reg;
         bus.rs = vec[i].rs; bus.rt = vec[i].rt; bus.disp = vec[i].disp;
         #1;
         chk($sformatf("v%0d_rd1", i), bus.rd1, vec[i].e_rd1);
         chk($sformatf("v%0d_rd2", i), bus.rd2, vec[i].e_rd2);
         chk($sformatf("v%0d_rs_busy", i), 32'(bus.rs_busy), 32'(vec[i].e_sb));
         chk($sformatf("v%0d_rt_busy", i), 32'(bus.rt_busy), 32'(vec[i].e_tb));
         chk($sformatf("v%0d_out", i), 32'(bus.out), 32'(vec[i].e_out));
      end
      @(negedge clk);
      idle_inputs();

      // dump with toggling ready, writes and spurious starts mid-stream
      fill();
      @(negedge clk);
      bus.dump_start = 1;
      for (int i = 0; i < 32; i++) begin
         e.idx = 5'(i); e.data = 32'(i * 3);
         q.push_back(e);
      end
      #1;
      chk("dump_valid_at_start_edge", 32'(bus.dump_valid), 0);
      stall = 0; accepted = 0; done_cnt = 0; tail = 0; cyc = 0; wrote = 0;
      held = '{idx: 0, data: 0};
      while (tail < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus.dump_start = (accepted == 3 || accepted == 4);
         bus.dump_ready = cyc[0];
         bus.write_reg = 0;
         if (accepted == 5 && !wrote) begin
            wrote = 1;
            bus.write_reg = 1; bus.wr = 20; bus.write = 32'h777;
            foreach (q[k]) if (q[k].idx == 5'd20) q[k].data = 32'h777;
         end
         #1;
         if (cyc == 1) begin
            chk("dump_first_valid", 32'(bus.dump_valid), 1);
            chk("dump_first_idx", 32'(bus.dump_idx), 0);
         end
         if (stall) begin
            chk("dump_hold_idx", 32'(bus.dump_idx), 32'(held.idx));
            chk("dump_hold_data", bus.dump_data, held.data);
         end
         if (bus.dump_valid && bus.dump_ready) begin
            if (q.size() == 0) begin
               chk("dump_extra_word", 32'(bus.dump_idx), 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk($sformatf("dump_idx_%0d", e.idx), 32'(bus.dump_idx), 32'(e.idx));
               chk($sformatf("dump_data_%0d", e.idx), bus.dump_data, e.data);
            end
            accepted++;
         end
         stall = bus.dump_valid && !bus.dump_ready;
         held.idx = bus.dump_idx; held.data = bus.dump_data;
         if (bus.dump_done) begin
            done_cnt++;
            chk("done_after_last", 32'(accepted), 32);
            chk("done_valid_low", 32'(bus.dump_valid), 0);
            chk("done_idx_zero", 32'(bus.dump_idx), 0);
         end
         if (done_cnt > 0) tail++;
      end
      chk("dump_finished_in_budget", 32'(cyc < 200), 1);
      chk("dump_words_accepted", 32'(accepted), 32);
      chk("dump_done_count", 32'(done_cnt), 1);
      bus.dump_start = 0; bus.dump_ready = 0; bus.write_reg = 0;

      // reset in the middle of a dump, ready held high
      @(negedge clk);
      bus.dump_start = 1; bus.dump_ready = 1;
      cyc = 0; done_cnt = 0;
      while (cyc < 50) begin
         @(negedge clk);
         bus.dump_start = 0;
         cyc++;
         #1;
         if (bus.dump_done) done_cnt++;
         if (bus.dump_valid && bus.dump_idx == 5'd10) break;
      end
      chk("rst_dump_idx10_cycle", 32'(cyc), 11);
      rst = 1;
      #1;
      chk("rst_valid_immediate", 32'(bus.dump_valid), 0);
      chk("rst_idx_immediate", 32'(bus.dump_idx), 0);
      @(negedge clk);
      rst = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (bus.dump_done) done_cnt++;
      end
      chk("rst_no_done", 32'(done_cnt), 0);
      chk("rst_stays_idle", 32'(bus.dump_valid), 0);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         bus.rs = 5'(i); bus.rt = 5'(31 - i); bus.disp = 5'(i);
         #1;
         if (bus.rd1 !== 0 || bus.rd2 !== 0 || bus.out !== 0 || bus.rs_busy !== 0)
            chk($sformatf("rst_clear_reg%0d", i), bus.rd1 | bus.rd2 | 32'(bus.out) | 32'(bus.rs_busy), 0);
      end
      tests++;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
